// File: rtl/substitui_bytes_inv_serial.sv
`default_nettype none
// ============================================================================
// Module   : substitui_bytes_inv_serial
// Purpose  : Inverse SubBytes stage of the decryption datapath. Each of the
//            16 state bytes is replaced by its inverse AES S-box value.
//            BYTES_POR_CICLO lookups are time-shared over N = 16/B cycles.
//            The MSB byte group is processed first.
// Ports    : clk, rst_n (async, active-low)
//            entrada_valida/entrada_pronta/bloco : upstream handshake + block
//            saida_valida/saida_pronta/saida     : downstream handshake + block
//            ocupado                             : high while a block is held
// Option   : SUBSTITUI_MODO_DIRETO_EN adds input modo_direto. It is sampled
//            at accept. When it is 1, the forward S-box is used for the block.
// Revision : 1.0 - initial release
// ============================================================================
module substitui_bytes_inv_serial #(
  parameter int BYTES_POR_CICLO = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         entrada_valida,
  output logic         entrada_pronta,
  input  logic [127:0] bloco,
`ifdef SUBSTITUI_MODO_DIRETO_EN
  input  logic         modo_direto,
`endif
  output logic         saida_valida,
  input  logic         saida_pronta,
  output logic [127:0] saida,
  output logic         ocupado
);

  localparam int N  = 16 / BYTES_POR_CICLO;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = 8 * BYTES_POR_CICLO;

  if (!(BYTES_POR_CICLO == 1 || BYTES_POR_CICLO == 2 || BYTES_POR_CICLO == 4 ||
        BYTES_POR_CICLO == 8 || BYTES_POR_CICLO == 16)) begin : g_param_invalido
    $error("BYTES_POR_CICLO must be 1, 2, 4, 8 or 16");
  end

  // Inverse S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  // Entry x sits at bit offset 8*(255-x) = {~x, 3'b000}.
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

`ifdef SUBSTITUI_MODO_DIRETO_EN
  localparam logic [2047:0] DIR_SBOX = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  function automatic logic [7:0] sbox_dir(input logic [7:0] x);
    return DIR_SBOX[{~x, 3'b000} +: 8];
  endfunction
`endif

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    PROCESSA  = 2'd1,
    CONCLUIDO = 2'd2
  } estado_t;

  estado_t         estado;
  estado_t         estado_prox;
  logic [CW-1:0]   contador;
  logic [127:0]    trabalho;
  logic [127:0]    trabalho_sub;
  logic            pronta_q;
  logic            ultimo;
  logic            aceita;
  logic [GW-1:0]   grupos [N];
  logic [GW-1:0]   grupo_sel;
  logic [GW-1:0]   grupo_sub;
`ifdef SUBSTITUI_MODO_DIRETO_EN
  logic            modo_q;
`endif

  assign ultimo = (contador == CW'(N - 1));
  assign aceita = entrada_valida && pronta_q;

  // Group g covers bytes 15-g*B down to 16-(g+1)*B.
  for (genvar g = 0; g < N; g++) begin : g_grupos
    assign grupos[g] = trabalho[(N - 1 - g) * GW +: GW];
    assign trabalho_sub[(N - 1 - g) * GW +: GW] =
        (contador == CW'(g)) ? grupo_sub : grupos[g];
  end

  if (N == 1) begin : g_sel_unico
    assign grupo_sel = grupos[0];
  end else begin : g_sel_mux
    assign grupo_sel = grupos[contador];
  end

  for (genvar j = 0; j < BYTES_POR_CICLO; j++) begin : g_sbox
`ifdef SUBSTITUI_MODO_DIRETO_EN
    assign grupo_sub[j * 8 +: 8] = modo_q ? sbox_dir(grupo_sel[j * 8 +: 8])
                                          : sbox_inv(grupo_sel[j * 8 +: 8]);
`else
    assign grupo_sub[j * 8 +: 8] = sbox_inv(grupo_sel[j * 8 +: 8]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:    if (aceita)       estado_prox = PROCESSA;
      PROCESSA:  if (ultimo)       estado_prox = CONCLUIDO;
      CONCLUIDO: if (saida_pronta) estado_prox = OCIOSO;
      default:                     estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador <= '0;
      trabalho <= '0;
      pronta_q <= 1'b0;
`ifdef SUBSTITUI_MODO_DIRETO_EN
      modo_q   <= 1'b0;
`endif
    end else begin
      // The ready flag is registered so that it stays low through reset.
      // It rises on the first edge after release.
      pronta_q <= (estado_prox == OCIOSO);
      if (estado == OCIOSO && aceita) begin
        trabalho <= bloco;
        contador <= '0;
`ifdef SUBSTITUI_MODO_DIRETO_EN
        modo_q   <= modo_direto;
`endif
      end else if (estado == PROCESSA) begin
        trabalho <= trabalho_sub;
        if (!ultimo) begin
          contador <= contador + CW'(1);
        end
      end
    end
  end

  assign entrada_pronta = pronta_q;
  assign saida          = trabalho;
  assign saida_valida   = (estado == CONCLUIDO);
  assign ocupado        = (estado != OCIOSO);

endmodule
`default_nettype wire

// File: doc/substitui_bytes_inv_serial.md
Name: substitui_bytes_inv_serial

Overview:
- Inverse SubBytes stage of the decryption datapath. Sits directly downstream of the inverse row-rotation stage and consumes its 128-bit output block.
- Replaces each of the 16 state bytes with its inverse AES S-box value.
- Uses a time-shared S-box bank of BYTES_POR_CICLO lookups, so a block takes several cycles.
- Valid/ready handshakes on both sides allow stalls from either neighbour.

Parameters:
- BYTES_POR_CICLO, 4, bytes substituted per cycle. Legal values: 1, 2, 4, 8, 16. Any other value is a compile-time error. N = 16 / BYTES_POR_CICLO processing cycles per block.

Ports:
- clk  in  1  clock, all state changes on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- entrada_valida  in  1  upstream block present on bloco
- entrada_pronta  out  1  stage can accept a block
- bloco  in  128  block from the row-rotation stage; bits 127:120 = byte 15 (row 0, column 0)
- saida_valida  out  1  result present on saida
- saida_pronta  in  1  downstream accepts result
- saida  out  128  substituted block, same byte positions as bloco
- ocupado  out  1  high in PROCESSA or CONCLUIDO

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = OCIOSO, counter = 0, internal block register = 0
  - saida = 0, saida_valida = 0, ocupado = 0
  - entrada_pronta = 0. It is a registered flag and rises on the first clk edge after rst_n goes high.
- Accept rule: a block is taken only on an edge where entrada_valida && entrada_pronta. bloco is sampled only on that edge; it is a don't-care at all other times.
- FSM OCIOSO:
  - entrada_pronta = 1
  - on accept: load bloco into the working register, counter = 0, go to PROCESSA, entrada_pronta = 0 from that edge.
- FSM PROCESSA:
  - each edge replaces bytes [15-counter*B .. 16-(counter+1)*B] (MSB group first) with the inverse S-box of themselves; counter += 1.
  - after the edge with counter = N-1: go to CONCLUIDO, saida_valida = 1, saida = working register.
  - entrada_valida is ignored in this state.
- FSM CONCLUIDO:
  - saida and saida_valida hold stable until saida_pronta = 1 on an edge. That is the handshake.
  - on handshake: saida_valida = 0, go to OCIOSO, entrada_pronta = 1 after that same edge.
  - no same-cycle accept of a new input during output handshake.
- Latency:
  - saida_valida is visible N edges after the accept edge. With B = 4: accept at edge k, saida_valida high after edge k+4.
  - minimum block-to-block interval: N + 2 cycles.
- S-box: a combinational 256-entry inverse AES S-box function, instantiated B times. Pure byte substitution; no widening or carries.
- Counter: ceil(log2(N)) bits, minimum 1 bit. It never wraps; it is cleared on accept.
- Reset during PROCESSA or CONCLUIDO aborts the block. The partial result is discarded and all outputs take reset values immediately.
- Byte order of saida matches bloco exactly. No permutation in this stage.

Optional Feature:
- Macro: SUBSTITUI_MODO_DIRETO_EN
- Defined:
  - adds input port modo_direto (1 bit), sampled with bloco at accept and held for the whole block.
  - modo_direto = 1 selects the forward AES S-box for all bytes of that block; modo_direto = 0 selects the inverse S-box.
  - this lets the encryption path reuse the block.
- Undefined: the port is absent, only inverse S-box logic is built, and behaviour is identical to modo_direto = 0.

Test Plan:
- Reset, then bloco = 0x63 repeated in all 16 bytes, entrada_valida pulse, saida_pronta = 1 -> saida = 0x0000...00 exactly 4 edges after the accept edge (B = 4); saida_valida high for 1 cycle.
- bloco = 0x00010203 repeated over 4 words -> saida = 0x5209 6AD5 repeated over 4 words; bytes checked in place.
- Backpressure: saida_pronta = 0 for 10 cycles after saida_valida -> saida stable, entrada_pronta = 0 throughout, ocupado = 1. Handshake on cycle 11, then entrada_pronta = 1 on the next cycle.
- Input during busy: change bloco and assert entrada_valida mid-PROCESSA -> no effect on the result; that block is accepted only once entrada_pronta returns.
- Reset mid-operation: drop rst_n at processing cycle 2 -> saida = 0, saida_valida = 0 asynchronously. After release, a fresh 0xFF block yields all bytes 0x7D.
- Run the first three scenarios with BYTES_POR_CICLO = 1 and 16, expecting latency 16 and 1. With SUBSTITUI_MODO_DIRETO_EN and modo_direto = 1, a block of all 0x00 yields all 0x63, and all 0x53 yields all 0xED.
